// File: rtl/cout_event_monitor.sv
// Counts overflow pulses from an upstream counter against an armed threshold,
// raising a held alarm when the threshold is reached and flagging any later pulses.
//
// state | meaning
// IDLE  | waiting for arm; outputs hold
// COUNT | armed, counting cout_in pulses toward thresh_q
// ALARM | threshold reached; irq high until ack, extra pulses set ovf
module cout_event_monitor #(
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cout_in,
  input  logic             arm,
  input  logic [EVT_W-1:0] thresh,
  input  logic             ack,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             irq,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [EVT_W-1:0] r_thresh_q;
  logic [EVT_W-1:0] w_thresh_nxt;
  logic [EVT_W-1:0] r_evt_cnt;
  logic [EVT_W-1:0] w_cnt_nxt;
  logic [EVT_W-1:0] w_cnt_inc;
  logic             r_irq;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_arm_ok;

  // In COUNT the count is always strictly below thresh_q, so the increment cannot wrap.
  assign w_cnt_inc = r_evt_cnt + {{(EVT_W-1){1'b0}}, 1'b1};
  assign w_arm_ok  = arm && (r_state != S_ALARM);

  always_comb begin
    w_state_nxt  = r_state;
    w_thresh_nxt = r_thresh_q;
    w_cnt_nxt    = r_evt_cnt;
    w_ovf_nxt    = r_ovf;
    case (r_state)
      S_IDLE, S_COUNT: begin
        if (w_arm_ok) begin
          w_thresh_nxt = thresh;
          w_cnt_nxt    = '0;
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = (thresh == '0) ? S_ALARM : S_COUNT;
        end else if ((r_state == S_COUNT) && cout_in) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_thresh_q) begin
            w_state_nxt = S_ALARM;
          end
        end
      end
      S_ALARM: begin
        if (cout_in) begin
          w_ovf_nxt = 1'b1;
        end
        if (ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_thresh_q <= '0;
      r_evt_cnt  <= '0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_thresh_q <= w_thresh_nxt;
      r_evt_cnt  <= w_cnt_nxt;
      r_irq      <= (w_state_nxt == S_ALARM);
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign evt_cnt = r_evt_cnt;
  assign irq     = r_irq;
  assign busy    = (r_state != S_IDLE);
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_cout_event_monitor.sv
// Self-checking bench for cout_event_monitor: directed scenarios with fixed
// expectations, then random traffic against a behavioural model.
module tb_cout_event_monitor;

  logic       clk;
  logic       rst;
  logic       cout_in;
  logic       arm;
  logic [7:0] thresh;
  logic       ack;
  logic [7:0] evt_cnt;
  logic       irq;
  logic       busy;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0 = idle, 1 = counting, 2 = alarm
  int m_mode = 0;
  int m_cnt  = 0;
  int m_thr  = 0;
  int m_ovf  = 0;

  cout_event_monitor #(.EVT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .cout_in (cout_in),
    .arm     (arm),
    .thresh  (thresh),
    .ack     (ack),
    .evt_cnt (evt_cnt),
    .irq     (irq),
    .busy    (busy),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model, and return 1 time unit after the edge.
  task automatic drive(input logic r, input logic a, input int t, input logic c, input logic k);
    rst = r; arm = a; thresh = t[7:0]; cout_in = c; ack = k;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_cnt = 0; m_thr = 0; m_ovf = 0;
    end else if (m_mode == 2) begin
      if (c) m_ovf = 1;
      if (k) m_mode = 0;
    end else if (a) begin
      m_thr = t & 255; m_cnt = 0; m_ovf = 0;
      m_mode = (m_thr == 0) ? 2 : 1;
    end else if (m_mode == 1 && c) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == m_thr) m_mode = 2;
    end
    #1;
    rst = 0; arm = 0; cout_in = 0; ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    drive(1, 1, 5, 1, 1);
    n_tests++;
    if ({evt_cnt, irq, busy, ovf} !== 11'd0) begin
      n_fail++; $display("FAIL reset_state: got cnt=%0d irq=%b busy=%b ovf=%b, want all 0", evt_cnt, irq, busy, ovf);
    end
  endtask

  task automatic test_basic;
    drive(0, 1, 3, 0, 0);
    n_tests++;
    if (busy !== 1'b1 || evt_cnt !== 8'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL basic_arm: got cnt=%0d irq=%b busy=%b, want 0 0 1", evt_cnt, irq, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 1, 0);
      n_tests++;
      if (evt_cnt !== k[7:0] || irq !== (k == 3) || busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_pulse%0d: got cnt=%0d irq=%b busy=%b, want %0d %b 1", k, evt_cnt, irq, busy, k, (k == 3));
      end
      if (k < 3) begin
        idle(15);
        n_tests++;
        if (evt_cnt !== k[7:0] || busy !== 1'b1 || irq !== 1'b0) begin
          n_fail++; $display("FAIL basic_hold%0d: got cnt=%0d busy=%b irq=%b, want %0d 1 0", k, evt_cnt, busy, irq, k);
        end
      end
    end
  endtask

  task automatic test_ack_ovf;
    drive(0, 0, 0, 1, 0);
    idle(3);
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd3 || ovf !== 1'b1 || irq !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL alarm_ovf: got cnt=%0d ovf=%b irq=%b busy=%b, want 3 1 1 1", evt_cnt, ovf, irq, busy);
    end
    drive(0, 0, 0, 0, 1);
    n_tests++;
    if (evt_cnt !== 8'd3 || ovf !== 1'b1 || irq !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL alarm_ack: got cnt=%0d ovf=%b irq=%b busy=%b, want 3 1 0 0", evt_cnt, ovf, irq, busy);
    end
    idle(4);
    n_tests++;
    if (ovf !== 1'b1 || evt_cnt !== 8'd3) begin
      n_fail++; $display("FAIL idle_sticky: got ovf=%b cnt=%0d, want 1 3", ovf, evt_cnt);
    end
  endtask

  task automatic test_zero_thresh;
    drive(0, 1, 0, 0, 0);
    n_tests++;
    if (irq !== 1'b1 || evt_cnt !== 8'd0 || busy !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL zero_thresh: got irq=%b cnt=%0d busy=%b ovf=%b, want 1 0 1 0", irq, evt_cnt, busy, ovf);
    end
    drive(0, 1, 9, 0, 0);
    n_tests++;
    if (irq !== 1'b1 || busy !== 1'b1 || evt_cnt !== 8'd0) begin
      n_fail++; $display("FAIL alarm_arm_ignored: got irq=%b busy=%b cnt=%0d, want 1 1 0", irq, busy, evt_cnt);
    end
    drive(0, 1, 9, 1, 1);
    n_tests++;
    if (irq !== 1'b0 || busy !== 1'b0 || ovf !== 1'b1 || evt_cnt !== 8'd0) begin
      n_fail++; $display("FAIL ack_cout_arm: got irq=%b busy=%b ovf=%b cnt=%0d, want 0 0 1 0", irq, busy, ovf, evt_cnt);
    end
  endtask

  task automatic test_restart;
    drive(0, 1, 10, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd5 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL restart_pre: got cnt=%0d ovf=%b, want 5 0", evt_cnt, ovf);
    end
    drive(0, 1, 2, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd0 || irq !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_prio: got cnt=%0d irq=%b busy=%b, want 0 0 1", evt_cnt, irq, busy);
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd2 || irq !== 1'b1) begin
      n_fail++; $display("FAIL restart_alarm: got cnt=%0d irq=%b, want 2 1", evt_cnt, irq);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 20, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd7) begin
      n_fail++; $display("FAIL rst_mid_pre: got cnt=%0d, want 7", evt_cnt);
    end
    drive(1, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd0 || busy !== 1'b0 || irq !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_count: got cnt=%0d busy=%b irq=%b ovf=%b, want 0 0 0 0", evt_cnt, busy, irq, ovf);
    end
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd0 || busy !== 1'b0 || irq !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got cnt=%0d busy=%b irq=%b ovf=%b, want 0 0 0 0", evt_cnt, busy, irq, ovf);
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 4, 1, 1);
    n_tests++;
    if (busy !== 1'b0 || irq !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_alarm: got busy=%b irq=%b ovf=%b, want 0 0 0", busy, irq, ovf);
    end
  endtask

  task automatic test_full_width;
    drive(0, 1, 255, 0, 0);
    for (int i = 0; i < 254; i++) drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd254 || irq !== 1'b0) begin
      n_fail++; $display("FAIL full_254: got cnt=%0d irq=%b, want 254 0", evt_cnt, irq);
    end
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd255 || irq !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_255: got cnt=%0d irq=%b ovf=%b, want 255 1 0", evt_cnt, irq, ovf);
    end
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (evt_cnt !== 8'd255 || ovf !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL full_nowrap: got cnt=%0d ovf=%b irq=%b, want 255 1 1", evt_cnt, ovf, irq);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_random;
    int t;
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), t,
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
      n_tests++;
      if (evt_cnt !== m_cnt[7:0] || irq !== (m_mode == 2) || busy !== (m_mode != 0) || ovf !== (m_ovf != 0)) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got cnt=%0d irq=%b busy=%b ovf=%b, want %0d %b %b %b",
                 i, evt_cnt, irq, busy, ovf, m_cnt, (m_mode == 2), (m_mode != 0), (m_ovf != 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; thresh = 8'd0; cout_in = 1'b0; ack = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_ack_ovf();
    test_zero_thresh();
    test_restart();
    test_reset_mid();
    test_full_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
